// File: rtl/i2s_audio_in.sv
// I2S receiver: brings async BCLK/LRCLK/DATA into the clk domain, deserializes
// standard I2S slots, qualifies framing and emits locked L/R pairs with a strobe.
module i2s_audio_in #(
    parameter int AUDIO_DW    = 16,
    parameter int LOCK_FRAMES = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i2s_bclk,
    input  logic                       i2s_lrclk,
    input  logic                       i2s_data,
    output logic signed [AUDIO_DW-1:0] out_l,
    output logic signed [AUDIO_DW-1:0] out_r,
    output logic                       sample_ce,
    output logic                       locked,
    output logic [5:0]                 slot_bits
);
    localparam int CNT_W  = $clog2(LOCK_FRAMES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  LOCK_N   = CNT_W'(LOCK_FRAMES);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);
    localparam logic [IDLE_W-1:0] IDLE_TRIP = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [5:0]        MIN_LEN  = 6'(AUDIO_DW);
    localparam logic [5:0]        MAX_LEN  = 6'd62;

    logic                bclk_p0, bclk_p1, bclk_p2;
    logic                lrclk_p0, lrclk_p1;
    logic                data_p0, data_p1;
    logic                rise;

    logic                first_edge;
    logic                slot_valid;
    logic                lr_prev;
    logic [5:0]          bit_cnt;
    logic [AUDIO_DW-1:0] slot_sr;
    logic signed [AUDIO_DW-1:0] l_hold;
    logic [5:0]          l_len;
    logic                l_ok;
    logic [5:0]          prev_len;
    logic [CNT_W-1:0]    cnt;
    logic [IDLE_W-1:0]   idle;

    logic [AUDIO_DW-1:0] slot_nx;
    logic [AUDIO_DW-1:0] word;
    logic [5:0]          len;
    logic [5:0]          fill;
    logic                good;
    logic [CNT_W-1:0]    cnt_nx;

    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (v == LOCK_N) ? v : v + CNT_W'(1);
    endfunction

    assign rise = bclk_p1 & ~bclk_p2;

    // Slot-end view of the current edge: the bit arriving now is the slot LSB,
    // and short slots are left-justified by zero-filling the low bits.
    always_comb begin
        slot_nx = slot_sr;
        if (bit_cnt < MIN_LEN) begin
            slot_nx = {slot_sr[AUDIO_DW-2:0], data_p1};
        end
        len  = sat_inc6(bit_cnt);
        fill = (len < MIN_LEN) ? (MIN_LEN - len) : 6'd0;
        word = slot_nx << fill;
        good = l_ok && (l_len == len) && (len >= MIN_LEN) && (len <= MAX_LEN);
        if (!good) begin
            cnt_nx = '0;
        end else if (len != prev_len) begin
            cnt_nx = CNT_W'(1);
        end else begin
            cnt_nx = sat_cnt(cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bclk_p0    <= 1'b0;
            bclk_p1    <= 1'b0;
            bclk_p2    <= 1'b0;
            lrclk_p0   <= 1'b0;
            lrclk_p1   <= 1'b0;
            data_p0    <= 1'b0;
            data_p1    <= 1'b0;
            first_edge <= 1'b1;
            slot_valid <= 1'b0;
            lr_prev    <= 1'b0;
            bit_cnt    <= '0;
            slot_sr    <= '0;
            l_hold     <= '0;
            l_len      <= '0;
            l_ok       <= 1'b0;
            prev_len   <= '0;
            cnt        <= '0;
            idle       <= '0;
            out_l      <= '0;
            out_r      <= '0;
            sample_ce  <= 1'b0;
            locked     <= 1'b0;
            slot_bits  <= '0;
        end else begin
            // Input synchronizers plus one delay stage for edge detection.
            bclk_p0   <= i2s_bclk;
            bclk_p1   <= bclk_p0;
            bclk_p2   <= bclk_p1;
            lrclk_p0  <= i2s_lrclk;
            lrclk_p1  <= lrclk_p0;
            data_p0   <= i2s_data;
            data_p1   <= data_p0;
            sample_ce <= 1'b0;

            if (rise) begin
                idle <= '0;
                if (first_edge) begin
                    first_edge <= 1'b0;
                    lr_prev    <= lrclk_p1;
                    bit_cnt    <= '0;
                end else if (lrclk_p1 != lr_prev) begin
                    bit_cnt <= '0;
                    slot_sr <= '0;
                    lr_prev <= lrclk_p1;
                    if (!slot_valid) begin
                        slot_valid <= 1'b1;
                    end else if (!lr_prev) begin
                        l_hold <= word;
                        l_len  <= len;
                        l_ok   <= 1'b1;
                    end else begin
                        l_ok     <= 1'b0;
                        cnt      <= cnt_nx;
                        prev_len <= len;
                        if (cnt_nx == LOCK_N) begin
                            out_l     <= l_hold;
                            out_r     <= word;
                            slot_bits <= len;
                            locked    <= 1'b1;
                            sample_ce <= 1'b1;
                        end else begin
                            out_l     <= '0;
                            out_r     <= '0;
                            slot_bits <= '0;
                            locked    <= 1'b0;
                        end
                    end
                end else begin
                    slot_sr <= slot_nx;
                    bit_cnt <= len;
                end
            end else if (idle != IDLE_MAX) begin
                idle <= idle + IDLE_W'(1);
                // BCLK has gone quiet: drop lock and restart framing from scratch.
                if (idle == IDLE_TRIP) begin
                    locked     <= 1'b0;
                    out_l      <= '0;
                    out_r      <= '0;
                    slot_bits  <= '0;
                    cnt        <= '0;
                    slot_valid <= 1'b0;
                    first_edge <= 1'b1;
                    l_ok       <= 1'b0;
                end
            end
        end
    end

endmodule
